// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file micro-op sequencer.
package regfile_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MOV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_SHOW
    } state_e;

    // LED register layout: {carry, zero, result[7:0]}
    localparam int LED_W         = 10;
    localparam int LED_CARRY_BIT = 9;
    localparam int LED_ZERO_BIT  = 8;
    localparam int LED_RES_W     = 8;

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// Register file port bundle: two read ports and one write port.
interface regfile_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] regA;
    logic [ADDR_W-1:0] regB;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic              RFWrite;
    logic [ADDR_W-1:0] regW;
    logic [DATA_W-1:0] dataW;

    modport master (
        output regA, regB, RFWrite, regW, dataW,
        input  dataA, dataB
    );

    modport slave (
        input  regA, regB, RFWrite, regW, dataW,
        output dataA, dataB
    );
endinterface

// File: rtl/regfile_seq_ctrl_rise_detect.sv
// Rising-edge detector: one-cycle pulse when level goes 0 -> 1.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_d <= 1'b0;
        else     level_d <= level;
    end

    assign pulse = level & ~level_d;
endmodule

// File: rtl/regfile_seq_ctrl.sv
// Single-issue sequencer: read rx/ry, compute, write rx, show result on LEDs.
module regfile_seq_ctrl
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int IMM_W       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [ADDR_W-1:0]   rx,
    input  logic [ADDR_W-1:0]   ry,
    input  logic [IMM_W-1:0]    imm,
    regfile_seq_ctrl_if.master  rf,
    output logic                led_en,
    output logic [LED_W-1:0]    led_data,
    output logic                busy,
    output logic                done
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               trigger;

    op_e                cmd_op;
    logic [ADDR_W-1:0]  cmd_rx, cmd_ry;
    logic [IMM_W-1:0]   cmd_imm;

    logic [DATA_W-1:0]  alu_res;
    logic               alu_carry;
    logic [DATA_W:0]    sum, diff;
    logic [LED_W-1:0]   led_nxt;

    logic [ADDR_W-1:0]  regw_q;
    logic [DATA_W-1:0]  dataw_q;
    logic [LED_W-1:0]   led_q;

    rise_detect u_start_rise (
        .clk   (CLOCK_50),
        .rst   (reset),
        .level (start),
        .pulse (trigger)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cmd_op  <= OP_LOAD;
            cmd_rx  <= '0;
            cmd_ry  <= '0;
            cmd_imm <= '0;
        end else if (state == ST_IDLE && trigger) begin
            cmd_op  <= op_e'(op);
            cmd_rx  <= rx;
            cmd_ry  <= ry;
            cmd_imm <= imm;
        end
    end

    assign rf.regA = cmd_rx;
    assign rf.regB = cmd_ry;

    // Borrow for SUB falls out of the extra top bit of the widened difference.
    always_comb begin
        sum       = {1'b0, rf.dataA} + {1'b0, rf.dataB};
        diff      = {1'b0, rf.dataA} - {1'b0, rf.dataB};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (cmd_op)
            OP_LOAD: alu_res = {{(DATA_W-IMM_W){1'b0}}, cmd_imm};
            OP_ADD:  begin alu_res = sum[DATA_W-1:0];  alu_carry = sum[DATA_W];  end
            OP_SUB:  begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; end
            OP_MOV:  alu_res = rf.dataB;
            default: alu_res = '0;
        endcase
        led_nxt                  = '0;
        led_nxt[LED_CARRY_BIT]   = alu_carry;
        led_nxt[LED_ZERO_BIT]    = (alu_res == '0);
        led_nxt[LED_RES_W-1:0]   = alu_res[LED_RES_W-1:0];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            regw_q  <= '0;
            dataw_q <= '0;
            led_q   <= '0;
        end else if (state == ST_EXEC) begin
            regw_q  <= cmd_rx;
            dataw_q <= alu_res;
            led_q   <= led_nxt;
        end
    end

    assign rf.regW  = regw_q;
    assign rf.dataW = dataw_q;
    assign led_data = led_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_WRITE;
            ST_WRITE: begin
                state_nxt = ST_SHOW;
                cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
            end
            ST_SHOW: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pulses decode straight from state so reset removes them asynchronously.
    assign busy       = (state != ST_IDLE);
    assign rf.RFWrite = (state == ST_WRITE);
    assign led_en     = (state == ST_WRITE);
    assign done       = (state == ST_SHOW) && (cnt == '0);
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Scoreboard bench for regfile_seq_ctrl with a behavioural 4x8 register file.
module tb_regfile_seq_ctrl;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [1:0] w;
        logic [7:0] d;
        logic [9:0] led;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op, rx, ry;
    logic [3:0] imm;
    logic       led_en, busy, done;
    logic [9:0] led_data;

    logic [7:0] rf_mem [4];
    logic       pre_en;
    logic [1:0] pre_addr;
    logic [7:0] pre_data;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    regfile_seq_ctrl_if #(.DATA_W(8), .ADDR_W(2)) rf_bus ();

    regfile_seq_ctrl #(
        .DATA_W(8), .ADDR_W(2), .IMM_W(4), .HOLD_CYCLES(HOLD)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .start    (start),
        .op       (op),
        .rx       (rx),
        .ry       (ry),
        .imm      (imm),
        .rf       (rf_bus),
        .led_en   (led_en),
        .led_data (led_data),
        .busy     (busy),
        .done     (done)
    );

    always #10 clk = ~clk;

    assign rf_bus.dataA = rf_mem[rf_bus.regA];
    assign rf_bus.dataB = rf_mem[rf_bus.regB];

    always @(posedge clk) begin
        if (pre_en)              rf_mem[pre_addr] <= pre_data;
        else if (rf_bus.RFWrite) rf_mem[rf_bus.regW] <= rf_bus.dataW;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_bus.RFWrite === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(rf_bus.regW), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("regW",     32'(rf_bus.regW),  32'(e.w));
                check("dataW",    32'(rf_bus.dataW), 32'(e.d));
                check("led_data", 32'(led_data),     32'(e.led));
                check("led_en",   32'(led_en),       32'd1);
            end
        end
    end

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // mode 0: normal pulse; 1: start held high; 2: extra rise during SHOW
    task automatic run_cmd(input logic [1:0] o, input logic [1:0] x, input logic [1:0] y,
                           input logic [3:0] im, input logic [7:0] ed, input logic [9:0] el,
                           input int mode);
        int   write_cyc = -1;
        int   done_cyc  = -1;
        int   nwr       = 0;
        int   ndone     = 0;
        logic busy_ok   = 1'b1;
        sb.push_back('{w: x, d: ed, led: el});
        @(posedge clk); #1;
        op = o; rx = x; ry = y; imm = im; start = 1'b1;
        for (int c = 0; c <= 3 + HOLD; c++) begin
            @(negedge clk);
            if (rf_bus.RFWrite === 1'b1) begin nwr++; if (write_cyc < 0) write_cyc = c; end
            if (done === 1'b1) begin ndone++; if (done_cyc < 0) done_cyc = c; end
            if (busy !== (c >= 1)) busy_ok = 1'b0;
            if (c == 1 && mode != 1) start = 1'b0;
            if (c == 2) begin op = ~o; rx = ~x; ry = ~y; imm = ~im; end
            if (mode == 2 && c == 4) start = 1'b1;
            if (mode == 2 && c == 5) start = 1'b0;
        end
        check("write_cycle",  32'(write_cyc), 32'd3);
        check("write_count",  32'(nwr),       32'd1);
        check("done_cycle",   32'(done_cyc),  32'(3 + HOLD));
        check("done_count",   32'(ndone),     32'd1);
        check("busy_profile", 32'(busy_ok),   32'd1);
    endtask

    task automatic idle_check(input int n);
        int nbusy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) nbusy++;
        end
        check("idle_busy", 32'(nbusy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; rx = '0; ry = '0; imm = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 4; i++) rf_mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",     32'(busy),           32'd0);
        check("rst_done",     32'(done),           32'd0);
        check("rst_rfwrite",  32'(rf_bus.RFWrite), 32'd0);
        check("rst_led_data", 32'(led_data),       32'd0);
        check("rst_dataW",    32'(rf_bus.dataW),   32'd0);
        rst = 1'b0;
        idle_check(2);

        // LOAD r2, 0xA
        run_cmd(2'b00, 2'd2, 2'd0, 4'hA, 8'h0A, 10'h00A, 0);
        // ADD with carry out, then SUB with borrow
        preload(2'd0, 8'hF0);
        preload(2'd1, 8'h20);
        run_cmd(2'b01, 2'd0, 2'd1, 4'h0, 8'h10, 10'h210, 0);
        preload(2'd0, 8'hF0);
        run_cmd(2'b10, 2'd1, 2'd0, 4'h0, 8'h30, 10'h230, 0);
        // SUB r3,r3 -> zero flag only
        preload(2'd3, 8'h05);
        run_cmd(2'b10, 2'd3, 2'd3, 4'h0, 8'h00, 10'h100, 0);

        // Held start: one command only
        run_cmd(2'b00, 2'd1, 2'd0, 4'h3, 8'h03, 10'h003, 1);
        idle_check(12);
        start = 1'b0;
        idle_check(3);
        // Second rise during SHOW is dropped
        run_cmd(2'b00, 2'd0, 2'd0, 4'hF, 8'h0F, 10'h00F, 2);
        idle_check(6);

        // Reset while in EXEC
        @(posedge clk); #1;
        op = 2'b01; rx = 2'd3; ry = 2'd1; imm = 4'h0; start = 1'b1;
        @(negedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_rfwrite",  32'(rf_bus.RFWrite), 32'd0);
        check("abort_busy",     32'(busy),           32'd0);
        check("abort_done",     32'(done),           32'd0);
        check("abort_led_en",   32'(led_en),         32'd0);
        check("abort_regA",     32'(rf_bus.regA),    32'd0);
        check("abort_led_data", 32'(led_data),       32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        idle_check(10);

        // Back-to-back: MOV reads the value the previous LOAD wrote
        run_cmd(2'b00, 2'd2, 2'd0, 4'h7, 8'h07, 10'h007, 0);
        run_cmd(2'b11, 2'd1, 2'd2, 4'h0, 8'h07, 10'h007, 0);
        run_cmd(2'b01, 2'd2, 2'd2, 4'h0, 8'h0E, 10'h00E, 0);
        idle_check(3);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
